// File: rtl/gbc_cartridge_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gbc_cartridge_bus_arbiter
// Description : Shares one cartridge backing-store Wishbone (pipelined) target
//               between the mapper's ROM initiator and cartridge-RAM
//               initiator. Grants ownership, tracks accepted-but-unacked
//               requests, routes ACK/data to the owner only, and maps RAM
//               addresses into a base window of the target address space.
// Ports       : CLK, RST (async, active-low)
//               ROM_* : ROM initiator   (CYC/STB/WE/ADDR/DAT_I in, DAT_O/ACK/STALL out)
//               RAM_* : RAM initiator   (same set, ADDR is RAM_AW wide)
//               T_*   : shared target   (CYC/STB/WE/ADDR/DAT_O out, DAT_I/ACK/STALL in)
//               GRANT : 01 ROM owns, 10 RAM owns, 00 idle
//               PROTO_ERR : sticky, target ACK seen with nothing outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module gbc_cartridge_bus_arbiter #(
    parameter int              ROM_AW         = 23,
    parameter int              RAM_AW         = 17,
    parameter int              DW             = 8,
    parameter int              TAW            = 24,
    parameter logic [TAW-1:0]  RAM_BASE       = 24'h800000,
    parameter int              MAX_OUT        = 4,
    parameter int              FIXED_PRIORITY = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ROM_CYC,
    input  logic              ROM_STB,
    input  logic              ROM_WE,
    input  logic [ROM_AW-1:0] ROM_ADDR,
    input  logic [DW-1:0]     ROM_DAT_I,
    output logic [DW-1:0]     ROM_DAT_O,
    output logic              ROM_ACK,
    output logic              ROM_STALL,
    input  logic              RAM_CYC,
    input  logic              RAM_STB,
    input  logic              RAM_WE,
    input  logic [RAM_AW-1:0] RAM_ADDR,
    input  logic [DW-1:0]     RAM_DAT_I,
    output logic [DW-1:0]     RAM_DAT_O,
    output logic              RAM_ACK,
    output logic              RAM_STALL,
    output logic              T_CYC,
    output logic              T_STB,
    output logic              T_WE,
    output logic [TAW-1:0]    T_ADDR,
    output logic [DW-1:0]     T_DAT_O,
    input  logic [DW-1:0]     T_DAT_I,
    input  logic              T_ACK,
    input  logic              T_STALL,
    output logic [1:0]        GRANT,
    output logic              PROTO_ERR
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_ROM = 2'd1,
        OWN_RAM = 2'd2
    } state_t;

    localparam logic       LAST_ROM  = 1'b0;
    localparam logic       LAST_RAM  = 1'b1;
    localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

    state_t      state_q, state_d;
    logic [3:0]  outstanding_q, outstanding_d;
    logic        last_q, last_d;
    logic        proto_err_q, proto_err_d;

    logic        rom_req, ram_req;
    logic        own_rom, owned;
    logic        sel_cyc, sel_stb, sel_we, other_req;
    logic [TAW-1:0] sel_addr;
    logic [DW-1:0]  sel_dat;
    logic        full, t_stb_w, accept, ack_ok;

    assign rom_req   = ROM_CYC & ROM_STB;
    assign ram_req   = RAM_CYC & RAM_STB;
    assign own_rom   = (state_q == OWN_ROM);
    assign owned     = (state_q == OWN_ROM) || (state_q == OWN_RAM);

    // Owner-side view of the request; only meaningful while owned.
    assign sel_cyc   = own_rom ? ROM_CYC   : RAM_CYC;
    assign sel_stb   = own_rom ? ROM_STB   : RAM_STB;
    assign sel_we    = own_rom ? ROM_WE    : RAM_WE;
    assign sel_dat   = own_rom ? ROM_DAT_I : RAM_DAT_I;
    assign sel_addr  = own_rom ? TAW'(ROM_ADDR) : (RAM_BASE + TAW'(RAM_ADDR));
    assign other_req = own_rom ? ram_req   : rom_req;

    assign full      = (outstanding_q == MAX_OUT_C);
    assign t_stb_w   = owned & sel_stb & ~full;
    assign accept    = t_stb_w & ~T_STALL;
    // An ACK with nothing outstanding is a protocol violation, never forwarded.
    assign ack_ok    = owned & T_ACK & (outstanding_q != 4'd0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            outstanding_q <= 4'd0;
            last_q        <= LAST_RAM;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            last_q        <= last_d;
            proto_err_q   <= proto_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        last_d        = last_q;
        proto_err_d   = proto_err_q;

        T_CYC     = 1'b0;
        T_STB     = 1'b0;
        T_WE      = 1'b0;
        T_ADDR    = '0;
        T_DAT_O   = '0;
        ROM_ACK   = 1'b0;
        ROM_STALL = 1'b1;
        ROM_DAT_O = '0;
        RAM_ACK   = 1'b0;
        RAM_STALL = 1'b1;
        RAM_DAT_O = '0;
        GRANT     = 2'b00;

        case (state_q)
            IDLE: begin
                // ACKs arriving here belong to an aborted owner: drop silently.
                outstanding_d = 4'd0;
                if (rom_req && ram_req) begin
                    state_d = ((FIXED_PRIORITY != 0) || (last_q == LAST_RAM)) ? OWN_ROM : OWN_RAM;
                end else if (rom_req) begin
                    state_d = OWN_ROM;
                end else if (ram_req) begin
                    state_d = OWN_RAM;
                end
            end

            OWN_ROM, OWN_RAM: begin
                T_CYC   = sel_cyc;
                T_STB   = t_stb_w;
                T_WE    = sel_we;
                T_ADDR  = sel_addr;
                T_DAT_O = sel_dat;
                if (own_rom) begin
                    GRANT     = 2'b01;
                    ROM_STALL = T_STALL | full;
                    ROM_ACK   = ack_ok;
                    ROM_DAT_O = T_DAT_I;
                end else begin
                    GRANT     = 2'b10;
                    RAM_STALL = T_STALL | full;
                    RAM_ACK   = ack_ok;
                    RAM_DAT_O = T_DAT_I;
                end

                if (accept && !ack_ok) begin
                    outstanding_d = outstanding_q + 4'd1;
                end else if (ack_ok && !accept) begin
                    outstanding_d = outstanding_q - 4'd1;
                end

                if (T_ACK && (outstanding_q == 4'd0)) begin
                    proto_err_d = 1'b1;
                end

                if (!sel_cyc) begin
                    // Abort: forget anything in flight.
                    state_d       = IDLE;
                    outstanding_d = 4'd0;
                    last_d        = own_rom ? LAST_ROM : LAST_RAM;
                end else if ((outstanding_q == 4'd0) && !sel_stb && other_req) begin
                    // Owner holds CYC but is quiet; hand the bus over.
                    state_d = IDLE;
                    last_d  = own_rom ? LAST_ROM : LAST_RAM;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign PROTO_ERR = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_gbc_cartridge_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gbc_cartridge_bus_arbiter
// Description : Directed, table-driven bench for gbc_cartridge_bus_arbiter,
//               plus hand-written multi-cycle sequences for the counter
//               limit, abort/late-ACK and asynchronous reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gbc_cartridge_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        rom_cyc, rom_stb, rom_we;
    logic [22:0] rom_addr;
    logic [7:0]  rom_dat_i, rom_dat_o;
    logic        rom_ack, rom_stall;
    logic        ram_cyc, ram_stb, ram_we;
    logic [16:0] ram_addr;
    logic [7:0]  ram_dat_i, ram_dat_o;
    logic        ram_ack, ram_stall;
    logic        t_cyc, t_stb, t_we;
    logic [23:0] t_addr;
    logic [7:0]  t_dat_o, t_dat_i;
    logic        t_ack, t_stall;
    logic [1:0]  grant;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;

    gbc_cartridge_bus_arbiter dut (
        .CLK       (clk),
        .RST       (rst),
        .ROM_CYC   (rom_cyc),
        .ROM_STB   (rom_stb),
        .ROM_WE    (rom_we),
        .ROM_ADDR  (rom_addr),
        .ROM_DAT_I (rom_dat_i),
        .ROM_DAT_O (rom_dat_o),
        .ROM_ACK   (rom_ack),
        .ROM_STALL (rom_stall),
        .RAM_CYC   (ram_cyc),
        .RAM_STB   (ram_stb),
        .RAM_WE    (ram_we),
        .RAM_ADDR  (ram_addr),
        .RAM_DAT_I (ram_dat_i),
        .RAM_DAT_O (ram_dat_o),
        .RAM_ACK   (ram_ack),
        .RAM_STALL (ram_stall),
        .T_CYC     (t_cyc),
        .T_STB     (t_stb),
        .T_WE      (t_we),
        .T_ADDR    (t_addr),
        .T_DAT_O   (t_dat_o),
        .T_DAT_I   (t_dat_i),
        .T_ACK     (t_ack),
        .T_STALL   (t_stall),
        .GRANT     (grant),
        .PROTO_ERR (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic [2:0]  romc;   // {cyc, stb, we}
        logic [22:0] ra;
        logic [7:0]  rd;
        logic [2:0]  ramc;   // {cyc, stb, we}
        logic [16:0] ma;
        logic [7:0]  md;
        logic [1:0]  tin;    // {ack, stall}
        logic [7:0]  td;
        logic [1:0]  g;
        logic [2:0]  tc;     // {cyc, stb, we}
        logic [23:0] ta;
        logic [7:0]  tdo;
        logic [1:0]  roms;   // {ack, stall}
        logic [7:0]  rdo;
        logic [1:0]  rams;   // {ack, stall}
        logic [7:0]  mdo;
        logic        pe;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input string n, input logic [2:0] romc, input logic [22:0] ra, input logic [7:0] rd,
        input logic [2:0] ramc, input logic [16:0] ma, input logic [7:0] md,
        input logic [1:0] tin, input logic [7:0] td,
        input logic [1:0] g, input logic [2:0] tc, input logic [23:0] ta, input logic [7:0] tdo,
        input logic [1:0] roms, input logic [7:0] rdo, input logic [1:0] rams, input logic [7:0] mdo,
        input logic pe);
        vec_t r;
        r.name = n; r.romc = romc; r.ra = ra; r.rd = rd; r.ramc = ramc; r.ma = ma; r.md = md;
        r.tin = tin; r.td = td; r.g = g; r.tc = tc; r.ta = ta; r.tdo = tdo;
        r.roms = roms; r.rdo = rdo; r.rams = rams; r.mdo = mdo; r.pe = pe;
        return r;
    endfunction

    function automatic logic [57:0] pack_out();
        return {grant, t_cyc, t_stb, t_we, t_addr, t_dat_o, rom_ack, rom_stall, rom_dat_o,
                ram_ack, ram_stall, ram_dat_o, proto_err};
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] romc, input logic [22:0] ra, input logic [7:0] rd,
                         input logic [2:0] ramc, input logic [16:0] ma, input logic [7:0] md,
                         input logic [1:0] tin, input logic [7:0] td);
        {rom_cyc, rom_stb, rom_we} = romc;
        rom_addr = ra; rom_dat_i = rd;
        {ram_cyc, ram_stb, ram_we} = ramc;
        ram_addr = ma; ram_dat_i = md;
        {t_ack, t_stall} = tin;
        t_dat_i = td;
    endtask

    // One bus cycle of stimulus: apply on the falling edge, sample 1 ns later.
    task automatic step(input logic [2:0] romc, input logic [22:0] ra,
                        input logic [1:0] tin, input logic [7:0] td);
        @(negedge clk);
        drive(romc, ra, 8'h00, 3'b000, 17'h0, 8'h00, tin, td);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(3'b000, 23'h0, 8'h00, 3'b000, 17'h0, 8'h00, 2'b00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        drive(3'b000, 23'h0, 8'h00, 3'b000, 17'h0, 8'h00, 2'b00, 8'h00);
        #1 rst = 1'b0;
        #1;
        // Reset values: idle grant, target quiet, both initiators stalled.
        chk("reset_outputs", 64'(pack_out()),
            64'({2'b00, 3'b000, 24'h0, 8'h00, 2'b01, 8'h00, 2'b01, 8'h00, 1'b0}));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        //             name           romc    ra       rd     ramc    ma      md     tin    td      g      tc      ta          tdo    roms   rdo    rams   mdo    pe
        vecs.push_back(v("t1_idle",    3'b110, 23'h10, 8'h00, 3'b000, 17'h0, 8'h00, 2'b00, 8'h00, 2'b00, 3'b000, 24'h000000, 8'h00, 2'b01, 8'h00, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t1_rd10",    3'b110, 23'h10, 8'h00, 3'b000, 17'h0, 8'h00, 2'b00, 8'h00, 2'b01, 3'b110, 24'h000010, 8'h00, 2'b00, 8'h00, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t1_rd11",    3'b110, 23'h11, 8'h00, 3'b000, 17'h0, 8'h00, 2'b10, 8'hD0, 2'b01, 3'b110, 24'h000011, 8'h00, 2'b10, 8'hD0, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t1_rd12",    3'b110, 23'h12, 8'h00, 3'b000, 17'h0, 8'h00, 2'b10, 8'hD1, 2'b01, 3'b110, 24'h000012, 8'h00, 2'b10, 8'hD1, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t1_rd13",    3'b110, 23'h13, 8'h00, 3'b000, 17'h0, 8'h00, 2'b10, 8'hD2, 2'b01, 3'b110, 24'h000013, 8'h00, 2'b10, 8'hD2, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t1_ack13",   3'b100, 23'h13, 8'h00, 3'b000, 17'h0, 8'h00, 2'b10, 8'hD3, 2'b01, 3'b100, 24'h000013, 8'h00, 2'b10, 8'hD3, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t1_hold",    3'b100, 23'h13, 8'h00, 3'b000, 17'h0, 8'h00, 2'b00, 8'h00, 2'b01, 3'b100, 24'h000013, 8'h00, 2'b00, 8'h00, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t1_drop",    3'b000, 23'h13, 8'h00, 3'b000, 17'h0, 8'h00, 2'b00, 8'h00, 2'b01, 3'b000, 24'h000013, 8'h00, 2'b00, 8'h00, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t2_idle",    3'b000, 23'h00, 8'h00, 3'b111, 17'h5, 8'hA5, 2'b00, 8'h00, 2'b00, 3'b000, 24'h000000, 8'h00, 2'b01, 8'h00, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t2_wr",      3'b000, 23'h00, 8'h00, 3'b111, 17'h5, 8'hA5, 2'b00, 8'h00, 2'b10, 3'b111, 24'h800005, 8'hA5, 2'b01, 8'h00, 2'b00, 8'h00, 1'b0));
        vecs.push_back(v("t2_ack",     3'b000, 23'h00, 8'h00, 3'b101, 17'h5, 8'hA5, 2'b10, 8'h3C, 2'b10, 3'b101, 24'h800005, 8'hA5, 2'b01, 8'h00, 2'b10, 8'h3C, 1'b0));
        vecs.push_back(v("t2_drop",    3'b000, 23'h00, 8'h00, 3'b000, 17'h5, 8'hA5, 2'b00, 8'h00, 2'b10, 3'b000, 24'h800005, 8'hA5, 2'b01, 8'h00, 2'b00, 8'h00, 1'b0));
        vecs.push_back(v("t2_quiet",   3'b000, 23'h00, 8'h00, 3'b000, 17'h0, 8'h00, 2'b00, 8'h00, 2'b00, 3'b000, 24'h000000, 8'h00, 2'b01, 8'h00, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t3_tie",     3'b110, 23'h20, 8'h00, 3'b110, 17'h7, 8'h00, 2'b00, 8'h00, 2'b00, 3'b000, 24'h000000, 8'h00, 2'b01, 8'h00, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t3_rom",     3'b110, 23'h20, 8'h00, 3'b110, 17'h7, 8'h00, 2'b00, 8'h00, 2'b01, 3'b110, 24'h000020, 8'h00, 2'b00, 8'h00, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t3_romack",  3'b100, 23'h20, 8'h00, 3'b110, 17'h7, 8'h00, 2'b10, 8'h55, 2'b01, 3'b100, 24'h000020, 8'h00, 2'b10, 8'h55, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t3_release", 3'b100, 23'h20, 8'h00, 3'b110, 17'h7, 8'h00, 2'b00, 8'h00, 2'b01, 3'b100, 24'h000020, 8'h00, 2'b00, 8'h00, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t3_gap",     3'b100, 23'h20, 8'h00, 3'b110, 17'h7, 8'h00, 2'b00, 8'h00, 2'b00, 3'b000, 24'h000000, 8'h00, 2'b01, 8'h00, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t3_ram",     3'b100, 23'h20, 8'h00, 3'b110, 17'h7, 8'h00, 2'b00, 8'h00, 2'b10, 3'b110, 24'h800007, 8'h00, 2'b01, 8'h00, 2'b00, 8'h00, 1'b0));
        vecs.push_back(v("t3_ramack",  3'b110, 23'h20, 8'h00, 3'b100, 17'h7, 8'h00, 2'b10, 8'h66, 2'b10, 3'b100, 24'h800007, 8'h00, 2'b01, 8'h00, 2'b10, 8'h66, 1'b0));
        vecs.push_back(v("t3_release2",3'b110, 23'h20, 8'h00, 3'b100, 17'h7, 8'h00, 2'b00, 8'h00, 2'b10, 3'b100, 24'h800007, 8'h00, 2'b01, 8'h00, 2'b00, 8'h00, 1'b0));
        vecs.push_back(v("t3_gap2",    3'b110, 23'h20, 8'h00, 3'b110, 17'h7, 8'h00, 2'b00, 8'h00, 2'b00, 3'b000, 24'h000000, 8'h00, 2'b01, 8'h00, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t3_tie_rom", 3'b110, 23'h20, 8'h00, 3'b110, 17'h7, 8'h00, 2'b00, 8'h00, 2'b01, 3'b110, 24'h000020, 8'h00, 2'b00, 8'h00, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t3_abort",   3'b000, 23'h00, 8'h00, 3'b000, 17'h0, 8'h00, 2'b00, 8'h00, 2'b01, 3'b000, 24'h000000, 8'h00, 2'b00, 8'h00, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t3_late_ack",3'b000, 23'h00, 8'h00, 3'b000, 17'h0, 8'h00, 2'b10, 8'h99, 2'b00, 3'b000, 24'h000000, 8'h00, 2'b01, 8'h00, 2'b01, 8'h00, 1'b0));
        vecs.push_back(v("t3_quiet",   3'b000, 23'h00, 8'h00, 3'b000, 17'h0, 8'h00, 2'b00, 8'h00, 2'b00, 3'b000, 24'h000000, 8'h00, 2'b01, 8'h00, 2'b01, 8'h00, 1'b0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].romc, vecs[i].ra, vecs[i].rd, vecs[i].ramc, vecs[i].ma, vecs[i].md,
                  vecs[i].tin, vecs[i].td);
            #1;
            chk(vecs[i].name, 64'(pack_out()),
                64'({vecs[i].g, vecs[i].tc, vecs[i].ta, vecs[i].tdo, vecs[i].roms, vecs[i].rdo,
                     vecs[i].rams, vecs[i].mdo, vecs[i].pe}));
        end

        // ---- Outstanding limit with MAX_OUT=4 and a silent target ----
        do_reset();
        step(3'b110, 23'h30, 2'b00, 8'h00);
        chk("t4_grant_gap", 64'({grant, rom_stall}), 64'({2'b00, 1'b1}));
        for (int k = 0; k < 4; k++) begin
            step(3'b110, 23'(23'h30 + k), 2'b00, 8'h00);
            chk($sformatf("t4_accept%0d", k), 64'({t_stb, rom_stall}), 64'({1'b1, 1'b0}));
        end
        step(3'b110, 23'h34, 2'b00, 8'h00);
        chk("t4_full", 64'({t_stb, rom_stall}), 64'({1'b0, 1'b1}));
        step(3'b110, 23'h34, 2'b10, 8'h11);
        chk("t4_full_ack", 64'({t_stb, rom_stall, rom_ack, rom_dat_o}), 64'({1'b0, 1'b1, 1'b1, 8'h11}));
        step(3'b110, 23'h34, 2'b10, 8'h12);
        chk("t4_ack_and_accept", 64'({t_stb, rom_stall, rom_ack}), 64'({1'b1, 1'b0, 1'b1}));
        step(3'b110, 23'h35, 2'b00, 8'h00);
        chk("t4_still_three", 64'({t_stb, rom_stall}), 64'({1'b1, 1'b0}));
        step(3'b110, 23'h36, 2'b00, 8'h00);
        chk("t4_full_again", 64'({t_stb, rom_stall}), 64'({1'b0, 1'b1}));

        // ---- Abort with 2 outstanding, late ACKs, then spurious ACK ----
        do_reset();
        step(3'b110, 23'h50, 2'b00, 8'h00);
        step(3'b110, 23'h50, 2'b00, 8'h00);
        step(3'b110, 23'h51, 2'b00, 8'h00);
        step(3'b000, 23'h51, 2'b00, 8'h00);
        chk("t5_abort_cycle", 64'({grant, t_cyc}), 64'({2'b01, 1'b0}));
        step(3'b000, 23'h00, 2'b10, 8'h99);
        chk("t5_late_ack1", 64'({grant, rom_ack, rom_dat_o, proto_err}), 64'({2'b00, 1'b0, 8'h00, 1'b0}));
        step(3'b000, 23'h00, 2'b10, 8'h9A);
        chk("t5_late_ack2", 64'({grant, rom_ack, rom_dat_o, proto_err}), 64'({2'b00, 1'b0, 8'h00, 1'b0}));
        step(3'b110, 23'h60, 2'b00, 8'h00);
        step(3'b100, 23'h60, 2'b10, 8'h77);
        chk("t5_spurious", 64'({grant, rom_ack, proto_err}), 64'({2'b01, 1'b0, 1'b0}));
        step(3'b100, 23'h60, 2'b00, 8'h00);
        chk("t5_proto_err_set", 64'(proto_err), 64'(1'b1));
        step(3'b000, 23'h60, 2'b00, 8'h00);
        chk("t5_proto_err_sticky", 64'(proto_err), 64'(1'b1));

        // ---- Asynchronous reset in the middle of a burst ----
        step(3'b110, 23'h40, 2'b00, 8'h00);
        step(3'b110, 23'h40, 2'b00, 8'h00);
        step(3'b110, 23'h41, 2'b00, 8'h00);
        step(3'b110, 23'h42, 2'b10, 8'h5A);
        chk("t6_pre_reset_ack", 64'({grant, rom_ack, rom_dat_o}), 64'({2'b01, 1'b1, 8'h5A}));
        #2 rst = 1'b0;
        #1;
        chk("t6_async_reset", 64'(pack_out()),
            64'({2'b00, 3'b000, 24'h0, 8'h00, 2'b01, 8'h00, 2'b01, 8'h00, 1'b0}));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_post_reset_idle", 64'({grant, rom_stall, rom_ack, proto_err}), 64'({2'b00, 1'b1, 1'b0, 1'b0}));
        step(3'b110, 23'h42, 2'b00, 8'h00);
        chk("t6_regrant", 64'({grant, t_stb, t_addr, rom_stall}), 64'({2'b01, 1'b1, 24'h000042, 1'b0}));
        step(3'b000, 23'h00, 2'b00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
